// File: rtl/mem_arbiter.sv
// mem_arbiter: merges the cpu instruction and data memory ports onto one external port,
// holding one pending request per port and routing each response back to its issuer.
module mem_arbiter #(
    parameter int PRIORITY = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        imemory_valid,
    input  logic        imemory_instr,
    input  logic [31:0] imemory_addr,
    input  logic [31:0] imemory_wdata,
    input  logic [3:0]  imemory_wstrb,
    output logic [31:0] imemory_rdata,
    output logic        imemory_ready,
    input  logic        dmemory_valid,
    input  logic        dmemory_instr,
    input  logic [31:0] dmemory_addr,
    input  logic [31:0] dmemory_wdata,
    input  logic [3:0]  dmemory_wstrb,
    output logic [31:0] dmemory_rdata,
    output logic        dmemory_ready,
    output logic        memory_valid,
    output logic        memory_instr,
    output logic [31:0] memory_addr,
    output logic [31:0] memory_wdata,
    output logic [3:0]  memory_wstrb,
    input  logic [31:0] memory_rdata,
    input  logic        memory_ready
);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
    state_t      state_q;
    logic        pend_i_q, pend_d_q, last_d_q;
    logic        i_instr_q, d_instr_q;
    logic [31:0] i_addr_q, i_wdata_q, d_addr_q, d_wdata_q;
    logic [3:0]  i_wstrb_q, d_wstrb_q;
    logic        mem_valid_q, mem_instr_q;
    logic [31:0] mem_addr_q, mem_wdata_q;
    logic [3:0]  mem_wstrb_q;
    logic        i_ready_q, d_ready_q;
    logic [31:0] i_rdata_q, d_rdata_q;
    logic        grant_d;

    // data wins unless the instruction port is also pending and round-robin says it is its turn
    assign grant_d = pend_d_q && (!pend_i_q || PRIORITY == 0 || !last_d_q);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pend_i_q    <= 1'b0;
            pend_d_q    <= 1'b0;
            last_d_q    <= 1'b1;
            i_instr_q   <= 1'b0;
            i_addr_q    <= '0;
            i_wdata_q   <= '0;
            i_wstrb_q   <= '0;
            d_instr_q   <= 1'b0;
            d_addr_q    <= '0;
            d_wdata_q   <= '0;
            d_wstrb_q   <= '0;
            mem_valid_q <= 1'b0;
            mem_instr_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            mem_valid_q <= 1'b0;
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
            if (imemory_valid && !pend_i_q) begin
                pend_i_q  <= 1'b1;
                i_instr_q <= imemory_instr;
                i_addr_q  <= imemory_addr;
                i_wdata_q <= imemory_wdata;
                i_wstrb_q <= imemory_wstrb;
            end
            if (dmemory_valid && !pend_d_q) begin
                pend_d_q  <= 1'b1;
                d_instr_q <= dmemory_instr;
                d_addr_q  <= dmemory_addr;
                d_wdata_q <= dmemory_wdata;
                d_wstrb_q <= dmemory_wstrb;
            end
            case (state_q)
                IDLE: if (pend_i_q || pend_d_q) begin
                    state_q     <= grant_d ? BUSY_D : BUSY_I;
                    last_d_q    <= grant_d;
                    mem_valid_q <= 1'b1;
                    mem_instr_q <= grant_d ? d_instr_q : i_instr_q;
                    mem_addr_q  <= grant_d ? d_addr_q : i_addr_q;
                    mem_wdata_q <= grant_d ? d_wdata_q : i_wdata_q;
                    mem_wstrb_q <= grant_d ? d_wstrb_q : i_wstrb_q;
                end
                BUSY_I, BUSY_D: if (memory_ready) begin
                    state_q     <= IDLE;
                    mem_instr_q <= 1'b0;
                    mem_addr_q  <= '0;
                    mem_wdata_q <= '0;
                    mem_wstrb_q <= '0;
                    if (state_q == BUSY_I) begin
                        pend_i_q  <= 1'b0;
                        i_ready_q <= 1'b1;
                        i_rdata_q <= memory_rdata;
                    end else begin
                        pend_d_q  <= 1'b0;
                        d_ready_q <= 1'b1;
                        d_rdata_q <= memory_rdata;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign memory_valid  = mem_valid_q;
    assign memory_instr  = mem_instr_q;
    assign memory_addr   = mem_addr_q;
    assign memory_wdata  = mem_wdata_q;
    assign memory_wstrb  = mem_wstrb_q;
    assign imemory_ready = i_ready_q;
    assign imemory_rdata = i_rdata_q;
    assign dmemory_ready = d_ready_q;
    assign dmemory_rdata = d_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: fixed-priority instance driven from a cycle table, round-robin instance
// and reset recovery exercised by hand-written sequences.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        iv[2], dv[2], mr[2], ir[2], dr[2], mv[2], mi[2];
    logic [31:0] ia[2], da[2], dw[2], mrd[2], ird[2], drd[2], ma[2], mw[2];
    logic [3:0]  ds[2], ms[2];
    int checks = 0;
    int errors = 0;

    mem_arbiter #(.PRIORITY(0)) u0 (
        .clock(clk), .reset(rst),
        .imemory_valid(iv[0]), .imemory_instr(1'b1), .imemory_addr(ia[0]),
        .imemory_wdata(32'd0), .imemory_wstrb(4'd0),
        .imemory_rdata(ird[0]), .imemory_ready(ir[0]),
        .dmemory_valid(dv[0]), .dmemory_instr(1'b0), .dmemory_addr(da[0]),
        .dmemory_wdata(dw[0]), .dmemory_wstrb(ds[0]),
        .dmemory_rdata(drd[0]), .dmemory_ready(dr[0]),
        .memory_valid(mv[0]), .memory_instr(mi[0]), .memory_addr(ma[0]),
        .memory_wdata(mw[0]), .memory_wstrb(ms[0]),
        .memory_rdata(mrd[0]), .memory_ready(mr[0])
    );

    mem_arbiter #(.PRIORITY(1)) u1 (
        .clock(clk), .reset(rst),
        .imemory_valid(iv[1]), .imemory_instr(1'b1), .imemory_addr(ia[1]),
        .imemory_wdata(32'd0), .imemory_wstrb(4'd0),
        .imemory_rdata(ird[1]), .imemory_ready(ir[1]),
        .dmemory_valid(dv[1]), .dmemory_instr(1'b0), .dmemory_addr(da[1]),
        .dmemory_wdata(dw[1]), .dmemory_wstrb(ds[1]),
        .dmemory_rdata(drd[1]), .dmemory_ready(dr[1]),
        .memory_valid(mv[1]), .memory_instr(mi[1]), .memory_addr(ma[1]),
        .memory_wdata(mw[1]), .memory_wstrb(ms[1]),
        .memory_rdata(mrd[1]), .memory_ready(mr[1])
    );

    typedef struct {
        logic         iv;
        logic [31:0]  ia;
        logic         dv;
        logic [31:0]  da;
        logic [31:0]  dw;
        logic [3:0]   ds;
        logic         mr;
        logic [31:0]  mrd;
        logic [135:0] exp;
    } vec_t;
    vec_t tv[20];

    function automatic logic [135:0] pk(input logic v, input logic i, input logic [31:0] a,
                                        input logic [31:0] w, input logic [3:0] s,
                                        input logic r_i, input logic [31:0] rd_i,
                                        input logic r_d, input logic [31:0] rd_d);
        return {v, i, a, w, s, r_i, rd_i, r_d, rd_d};
    endfunction

    function automatic logic [135:0] act(input int k);
        return pk(mv[k], mi[k], ma[k], mw[k], ms[k], ir[k], ird[k], dr[k], drd[k]);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [135:0] got, input logic [135:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, want);
        end
    endtask

    // waits for the round-robin instance to issue, checks the grant, then completes it
    task automatic rr_txn(input logic e_i, input logic [31:0] e_a);
        int n = 0;
        while (mv[1] !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        check("rr_grant", {127'd0, mv[1], mi[1], ma[1]}, {127'd0, 1'b1, e_i, e_a});
        mr[1]  = 1'b1;
        mrd[1] = ~e_a;
        step();
        mr[1]  = 1'b0;
        check("rr_resp", {66'd0, ir[1], dr[1], (e_i ? ird[1] : drd[1])},
              {66'd0, e_i, ~e_i, ~e_a});
    endtask

    initial begin
        logic bad;
        localparam logic [31:0] DB = 32'hDEADBEEF;
        localparam logic [31:0] R1 = 32'h11111111;
        localparam logic [31:0] R2 = 32'h22222222;
        tv[0]  = '{1, 32'h100, 0, 0, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0, 0, 0)};
        tv[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, 0, 0, 0)};
        tv[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, pk(1, 1, 32'h100, 0, 0, 0, 0, 0, 0)};
        tv[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, pk(0, 1, 32'h100, 0, 0, 0, 0, 0, 0)};
        tv[4]  = '{0, 0, 0, 0, 0, 0, 1, DB, pk(0, 1, 32'h100, 0, 0, 0, 0, 0, 0)};
        tv[5]  = '{0, 0, 0, 0, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 1, DB, 0, 0)};
        tv[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, DB, 0, 0)};
        tv[7]  = '{1, 32'h10, 1, 32'h20, 32'h12345678, 4'hF, 0, 0, pk(0, 0, 0, 0, 0, 0, DB, 0, 0)};
        tv[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, DB, 0, 0)};
        tv[9]  = '{0, 0, 1, 32'h99, 0, 0, 0, 0, pk(1, 0, 32'h20, 32'h12345678, 4'hF, 0, DB, 0, 0)};
        tv[10] = '{0, 0, 0, 0, 0, 0, 1, 32'hAA, pk(0, 0, 32'h20, 32'h12345678, 4'hF, 0, DB, 0, 0)};
        tv[11] = '{0, 0, 1, 32'h40, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, DB, 1, 32'hAA)};
        tv[12] = '{0, 0, 0, 0, 0, 0, 0, 0, pk(1, 1, 32'h10, 0, 0, 0, DB, 0, 32'hAA)};
        tv[13] = '{0, 0, 0, 0, 0, 0, 1, R1, pk(0, 1, 32'h10, 0, 0, 0, DB, 0, 32'hAA)};
        tv[14] = '{0, 0, 0, 0, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 1, R1, 0, 32'hAA)};
        tv[15] = '{0, 0, 0, 0, 0, 0, 1, R2, pk(1, 0, 32'h40, 0, 0, 0, R1, 0, 32'hAA)};
        tv[16] = '{0, 0, 0, 0, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, R1, 1, R2)};
        tv[17] = '{0, 0, 0, 0, 0, 0, 1, 32'h33, pk(0, 0, 0, 0, 0, 0, R1, 0, R2)};
        tv[18] = '{0, 0, 0, 0, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, R1, 0, R2)};
        tv[19] = '{0, 0, 0, 0, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 0, R1, 0, R2)};
        for (int k = 0; k < 2; k++) begin
            iv[k] = 0; dv[k] = 0; mr[k] = 0;
            ia[k] = 0; da[k] = 0; dw[k] = 0; ds[k] = 0; mrd[k] = 0;
        end
        rst = 1'b1;
        step();
        step();
        check("reset_p0", act(0), '0);
        check("reset_p1", act(1), '0);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            iv[0] = tv[i].iv; ia[0] = tv[i].ia;
            dv[0] = tv[i].dv; da[0] = tv[i].da; dw[0] = tv[i].dw; ds[0] = tv[i].ds;
            mr[0] = tv[i].mr; mrd[0] = tv[i].mrd;
            check($sformatf("vec%0d", i), act(0), tv[i].exp);
            step();
        end
        iv[0] = 0; dv[0] = 0; mr[0] = 0;

        dv[1] = 1; da[1] = 32'h200;
        step();
        dv[1] = 0;
        rr_txn(1'b0, 32'h200);
        iv[1] = 1; ia[1] = 32'h300; dv[1] = 1; da[1] = 32'h400;
        step();
        iv[1] = 0; dv[1] = 0;
        rr_txn(1'b1, 32'h300);
        rr_txn(1'b0, 32'h400);
        iv[1] = 1; ia[1] = 32'h500;
        step();
        iv[1] = 0;
        rr_txn(1'b1, 32'h500);
        iv[1] = 1; ia[1] = 32'h600; dv[1] = 1; da[1] = 32'h700;
        step();
        iv[1] = 0; dv[1] = 0;
        rr_txn(1'b0, 32'h700);
        rr_txn(1'b1, 32'h600);

        iv[0] = 1; ia[0] = 32'h80; dv[0] = 1; da[0] = 32'h84; dw[0] = 32'h5; ds[0] = 4'h3;
        step();
        iv[0] = 0; dv[0] = 0;
        step();
        check("busy_d", act(0), pk(1, 0, 32'h84, 32'h5, 4'h3, 0, R1, 0, R2));
        #2 rst = 1'b1;
        #1 check("async_reset", act(0), '0);
        @(posedge clk);
        #1 rst = 1'b0;
        mr[0] = 1; mrd[0] = 32'h55;
        step();
        mr[0] = 0;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bad |= mv[0] | ir[0] | dr[0];
            step();
        end
        check("post_reset_quiet", {135'd0, bad}, '0);
        iv[0] = 1; ia[0] = 32'h90;
        step();
        iv[0] = 0;
        step();
        check("post_reset_req", act(0), pk(1, 1, 32'h90, 0, 0, 0, 0, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
